// File: rtl/stage_buf.sv
// stage_buf: elastic pipeline register between CPU stages.
// DEPTH-entry circular buffer that carries a datapath bus and a commit-info bus.
// Both sides use a valid/ready handshake. flush squashes every entry that is in flight.
// in_ready and out_valid depend only on registered occupancy, so no combinational
// path runs from out_ready to in_ready.
// Optional feature: define STAGE_BUF_PERF_EN to add the stall_cnt and bubble_cnt
// performance counters.
module stage_buf #(
  parameter int BUS_W    = 96,
  parameter int COMMIT_W = 161,
  parameter int DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BUS_W-1:0]        in_bus,
  input  logic [COMMIT_W-1:0]     in_commit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BUS_W-1:0]        out_bus,
  output logic [COMMIT_W-1:0]     out_commit,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef STAGE_BUF_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             bubble_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [BUS_W-1:0]    bus_mem    [DEPTH];
  logic [COMMIT_W-1:0] commit_mem [DEPTH];
  logic                push;
  logic                pop;

  // Handshake qualifiers and the head-entry output mux. Outputs are zero while empty.
  always_comb begin
    // NOTE: assign every output a default first so that no path leaves a signal unassigned; an unassigned path infers a latch.
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_bus    = '0;
    out_commit = '0;
    in_ready   = (occupancy != FULL);
    out_valid  = (occupancy != '0);
    if (out_valid) begin
      out_bus    = bus_mem[rd_ptr];
      out_commit = commit_mem[rd_ptr];
    end
  end

  // flush blocks both push and pop, so it takes priority over every handshake event.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Pointers and occupancy. flush returns the buffer to its reset arrangement.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all sequential state uses non-blocking assignments, so each flop samples values from before the edge.
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Entry storage. It is written only on an accepted push. An entry is never
  // overwritten while it is the head, so held outputs stay stable.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the entries are cleared on reset so the buffer always restarts from all-zero.
    // The buffer is shallow, so these are flops rather than a RAM macro.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bus_mem[i]    <= '0;
        commit_mem[i] <= '0;
      end
    end else if (push) begin
      bus_mem[wr_ptr]    <= in_bus;
      commit_mem[wr_ptr] <= in_commit;
    end
  end

`ifdef STAGE_BUF_PERF_EN
  // Saturating stall and bubble counters. Only reset clears them; flush does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid && !flush && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  // The performance counters are absent. The datapath is unchanged.
`endif

endmodule
